mem_byte_sequencer: RTL
=======================

# mem_byte_sequencer

Memory-side sequencer between the datapath's MAR/MDR/control signals and a byte-wide synchronous RAM port. It turns one MOV request of 1, 2 or 4 bytes into back-to-back single-byte RAM beats. On loads it assembles a big-endian word, with zero or sign extension. It signals completion to the control unit with MOC on a four-phase MOV/MOC handshake. It replaces direct word access to RAM, so the control unit's wait-for-MOC states see true multi-cycle memory latency.

## Interface
Parameters:
- ADDR_W, 8, byte-address width of the RAM port.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- MOV  in  1  memory operation valid from the control unit.
- RW  in  1  1 = read (load), 0 = write (store).
- MS  in  3  MS[1:0] size (00 byte, 01 halfword, 10 word, 11 illegal); MS[2] = sign-extend loads.
- ADDR  in  32  byte address from MAR.
- DATA_IN  in  32  store data from MDR.
- DATA_OUT  out  32  load result to IR/MDR.
- MOC  out  1  memory operation complete.
- ERR  out  1  last request had an illegal size.
- MEM_ADDR  out  ADDR_W  RAM byte address.
- MEM_WDATA  out  8  RAM write byte.
- MEM_WE  out  1  RAM write strobe, one byte per cycle.
- MEM_RE  out  1  RAM read strobe. Data returns on MEM_RDATA the following cycle.
- MEM_RDATA  in  8  RAM read byte.

## Operation
- FSM states:
  - IDLE → on MOV=1, latch RW, MS, aligned ADDR and DATA_IN; go to XFER (legal size) or DONE with ERR=1 (size 11, no RAM beat).
  - XFER → issue N beats (N = 1/2/4); for reads, wait for the last returned byte; go to DONE.
  - DONE → hold MOC=1 while MOV=1; on MOV=0 drop MOC and go to IDLE.
- Alignment: halfword clears ADDR[0]; word clears ADDR[1:0]. The address is truncated to ADDR_W bits, so no access crosses the top of memory.
- Big-endian: the byte at the lowest address is the most significant byte of the N-byte field.
- Store:
  - Beat k writes byte k of the low N bytes of DATA_IN, MSB first, to MEM_ADDR = base + k.
  - Byte store writes DATA_IN[7:0]; halfword store writes DATA_IN[15:8] then DATA_IN[7:0].
- Load:
  - Bytes shift into an assembly register.
  - Byte and halfword results are zero-extended when MS[2]=0 and sign-extended when MS[2]=1.
  - Word results ignore MS[2].
- DATA_OUT updates only when a load completes; stores and errors leave it unchanged.
- ERR is set on an illegal request and cleared when the next request is accepted.
- Input changes after acceptance are ignored until the FSM returns to IDLE.

## Timing
- Reset values: DATA_OUT=0, MOC=0, ERR=0, MEM_WE=0, MEM_RE=0, MEM_ADDR=0, MEM_WDATA=0, state IDLE.
- Let E0 be the edge that samples MOV=1 in IDLE.
- Beat k (k = 0..N-1) is driven in the cycle after edge Ek: exactly one strobe high, with address and data valid.
- Store: MOC is high starting from the cycle after edge EN.
- Load: byte k is captured at edge E(k+2). MOC and the final DATA_OUT both go high/valid starting from the cycle after edge E(N+1).
- Illegal size: MOC and ERR are both high in the cycle after E0.
- MOC falls in the cycle after the edge that samples MOV=0 in DONE. A new request is accepted only from IDLE, so keeping MOV high never starts a second access.
- RESET mid-access: at the next edge all outputs return to reset values and the access is aborted. Bytes already written stay written.
- RESET has priority over every other event.

## Structure
- Shared package mem_seq_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL);
  - the FSM state enum;
  - a function returning N from the size.
- One sub-module, load_extender: a combinational block that takes the assembled 32-bit value, the size and the sign bit and returns the extended load result.
- FSM, beat counter and assembly register live in the top module.

## Test plan
- Word load, RAM[0x10..0x13] = E3,A0,10,05, ADDR=0x12, MS=010 → four reads at 0x10..0x13; DATA_OUT=E3A01005; MOC from cycle after E5.
- Byte load, RAM[0x07]=0x80: MS=100 → DATA_OUT=FFFFFF80; MS=000 → DATA_OUT=00000080. MOC from cycle after E2.
- Halfword store, DATA_IN=ABCD1234, ADDR=0x21, MS=001 → RAM[0x20]=12, RAM[0x21]=34; MOC from cycle after E2; DATA_OUT unchanged.
- Illegal size, MS=011 → no MEM_WE/MEM_RE pulse; MOC=1 and ERR=1 in the cycle after E0. The next legal request clears ERR.
- RESET asserted after two beats of a word store → only two bytes written; all outputs are at reset values after that edge; a following byte read completes normally.
- MOV held high 5 cycles past MOC → MOC stays 1, no extra beats; MOV low → MOC 0 one cycle later.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared size encodings, FSM state type and beat-count helper for the
// byte-wide memory sequencer.
package mem_seq_pkg;

   localparam logic [1:0] SZ_BYTE    = 2'b00;
   localparam logic [1:0] SZ_HALF    = 2'b01;
   localparam logic [1:0] SZ_WORD    = 2'b10;
   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

   function automatic logic [2:0] beats_of(input logic [1:0] size);
      case (size)
         SZ_BYTE: beats_of = 3'd1;
         SZ_HALF: beats_of = 3'd2;
         SZ_WORD: beats_of = 3'd4;
         default: beats_of = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/mem_byte_sequencer_load_extender.sv
// Zero/sign extension of an assembled big-endian load value to 32 bits.
module load_extender
   import mem_seq_pkg::*;
(
   input  logic [31:0] i_raw,
   input  logic [1:0]  i_size,
   input  logic        i_sign,
   output logic [31:0] o_data
);

   always_comb begin
      o_data = i_raw;
      case (i_size)
         SZ_BYTE: o_data = i_sign ? {{24{i_raw[7]}}, i_raw[7:0]}
                                  : {24'h000000, i_raw[7:0]};
         SZ_HALF: o_data = i_sign ? {{16{i_raw[15]}}, i_raw[15:0]}
                                  : {16'h0000, i_raw[15:0]};
         default: o_data = i_raw;
      endcase
   end

endmodule

// File: rtl/mem_byte_sequencer.sv
// Splits one MOV request of 1/2/4 bytes into single-byte RAM beats and
// answers with MOC on a four-phase MOV/MOC handshake.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for MOV; latches request and drives beat 0
// ST_XFER | issuing remaining beats, collecting read bytes
// ST_DONE | MOC high until MOV drops
module mem_byte_sequencer
   import mem_seq_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              MOV,
   input  logic              RW,
   input  logic [2:0]        MS,
   input  logic [31:0]       ADDR,
   input  logic [31:0]       DATA_IN,
   output logic [31:0]       DATA_OUT,
   output logic              MOC,
   output logic              ERR,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [7:0]        MEM_WDATA,
   output logic              MEM_WE,
   output logic              MEM_RE,
   input  logic [7:0]        MEM_RDATA
);

   seq_state_t        r_state;
   logic              r_rw;
   logic [1:0]        r_size;
   logic              r_sign;
   logic [ADDR_W-1:0] r_base;
   logic [31:0]       r_wdata;
   logic [2:0]        r_beat;
   logic [2:0]        r_rx_left;
   logic              r_re_d;
   logic [31:0]       r_asm;

   logic [ADDR_W-1:0] w_base;
   logic [2:0]        w_nbeats_in;
   logic [2:0]        w_nbeats;
   logic [31:0]       w_asm_next;
   logic [31:0]       w_load;
   logic              w_unused_addr;

   // Byte k of the low nb bytes, counted from the most significant end.
   function automatic logic [7:0] pick_byte(input logic [31:0] d,
                                            input logic [2:0]  nb,
                                            input logic [2:0]  k);
      logic [2:0]  idx;
      logic [31:0] s;
      idx = nb - k - 3'd1;
      s   = d >> {idx, 3'b000};
      return s[7:0];
   endfunction

   assign w_unused_addr = &{1'b0, ADDR[31:ADDR_W]};
   assign w_nbeats_in   = beats_of(MS[1:0]);
   assign w_nbeats      = beats_of(r_size);
   assign w_asm_next    = {r_asm[23:0], MEM_RDATA};

   always_comb begin
      w_base = ADDR[ADDR_W-1:0];
      if (MS[1:0] == SZ_HALF)
         w_base[0] = 1'b0;
      else if (MS[1:0] == SZ_WORD)
         w_base[1:0] = 2'b00;
   end

   load_extender u_load_extender (
      .i_raw  (w_asm_next),
      .i_size (r_size),
      .i_sign (r_sign),
      .o_data (w_load)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state   <= ST_IDLE;
         r_rw      <= 1'b0;
         r_size    <= SZ_BYTE;
         r_sign    <= 1'b0;
         r_base    <= '0;
         r_wdata   <= '0;
         r_beat    <= '0;
         r_rx_left <= '0;
         r_re_d    <= 1'b0;
         r_asm     <= '0;
         DATA_OUT  <= '0;
         MOC       <= 1'b0;
         ERR       <= 1'b0;
         MEM_ADDR  <= '0;
         MEM_WDATA <= '0;
         MEM_WE    <= 1'b0;
         MEM_RE    <= 1'b0;
      end else begin
         // A read strobe in the previous cycle means MEM_RDATA is valid now.
         r_re_d <= MEM_RE;
         case (r_state)
            ST_IDLE: begin
               MEM_WE <= 1'b0;
               MEM_RE <= 1'b0;
               if (MOV) begin
                  r_rw      <= RW;
                  r_size    <= MS[1:0];
                  r_sign    <= MS[2];
                  r_base    <= w_base;
                  r_wdata   <= DATA_IN;
                  r_asm     <= '0;
                  r_beat    <= 3'd1;
                  r_rx_left <= w_nbeats_in;
                  if (MS[1:0] == SZ_ILLEGAL) begin
                     ERR     <= 1'b1;
                     MOC     <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     ERR       <= 1'b0;
                     MEM_ADDR  <= w_base;
                     MEM_WDATA <= RW ? 8'h00 : pick_byte(DATA_IN, w_nbeats_in, 3'd0);
                     MEM_WE    <= ~RW;
                     MEM_RE    <= RW;
                     r_state   <= ST_XFER;
                  end
               end
            end
            ST_XFER: begin
               if (r_beat != w_nbeats) begin
                  MEM_ADDR  <= r_base + ADDR_W'(r_beat);
                  MEM_WDATA <= r_rw ? 8'h00 : pick_byte(r_wdata, w_nbeats, r_beat);
                  MEM_WE    <= ~r_rw;
                  MEM_RE    <= r_rw;
                  r_beat    <= r_beat + 3'd1;
               end else begin
                  MEM_WE <= 1'b0;
                  MEM_RE <= 1'b0;
                  if (!r_rw) begin
                     MOC     <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end
               if (r_rw && r_re_d) begin
                  r_asm     <= w_asm_next;
                  r_rx_left <= r_rx_left - 3'd1;
                  if (r_rx_left == 3'd1) begin
                     DATA_OUT <= w_load;
                     MOC      <= 1'b1;
                     r_state  <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               MEM_WE <= 1'b0;
               MEM_RE <= 1'b0;
               if (!MOV) begin
                  MOC     <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
